if_id_buffer: RTL and testbench

//   Instruction buffer between the AXI fetch stage and decode. It queues fetched
//   {pc, inst} pairs in a small FIFO and presents the head entry to decode.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/if_id_buffer.sv | 109 ++++++++++
 tb/tb_if_id_buffer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared MIPS pipeline constants and the IF/ID buffer entry type.
//            Optional macro IFID_ADEL_CHECK_EN adds a per-entry address-error flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int          XLEN     = 32;
  localparam int          IMM_W    = 16;
  localparam logic [31:0] INST_NOP = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
`ifdef IFID_ADEL_CHECK_EN
    logic            adel;
`endif
  } ifid_entry_t;

endpackage

`default_nettype wire

// File: rtl/if_id_buffer.sv
// ============================================================================
// Module   : if_id_buffer
// Brief    : Small FIFO of fetched {pc, inst} pairs feeding decode; flush drops
//            all entries. Optional macro IFID_ADEL_CHECK_EN adds id_adel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_buffer
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [XLEN-1:0]  if_inst,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [XLEN-1:0]  id_pc,
  output logic [XLEN-1:0]  id_inst,
`ifdef IFID_ADEL_CHECK_EN
  output logic             id_adel,
`endif
  output logic [IMM_W-1:0] id_imm
);

  localparam logic [PTR_W:0] c_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] c_ZERO = '0;

  ifid_entry_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [XLEN-1:0]  r_last_pc;

  logic             w_push;
  logic             w_pop;
  ifid_entry_t      w_head;
  ifid_entry_t      w_wr_entry;

  // Handshake flags come only from registered count, never from id_ready.
  assign if_ready = (r_count != c_FULL);
  assign id_valid = (r_count != c_ZERO);

  assign w_push = if_valid & if_ready & ~flush;
  assign w_pop  = id_valid & id_ready & ~flush;
  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    w_wr_entry      = '0;
    w_wr_entry.pc   = if_pc;
    w_wr_entry.inst = if_inst;
`ifdef IFID_ADEL_CHECK_EN
    w_wr_entry.adel = (if_pc[1:0] != 2'b00);
`endif
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_last_pc <= RESET_PC;
    end else if (flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
        r_last_pc <= w_head.pc;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign id_pc = id_valid ? w_head.pc : r_last_pc;

`ifdef IFID_ADEL_CHECK_EN
  // A misaligned fetch reaches decode as a NOP carrying the exception.
  assign id_adel = w_head.adel & id_valid;
  assign id_inst = (id_valid && !w_head.adel) ? w_head.inst : INST_NOP;
`else
  assign id_inst = id_valid ? w_head.inst : INST_NOP;
`endif

  assign id_imm = id_inst[IMM_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_if_id_buffer.sv
// ============================================================================
// Module   : tb_if_id_buffer
// Brief    : Directed, table-driven self-checking bench for if_id_buffer.
//            Address-error vectors are built only with IFID_ADEL_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [15:0] id_imm;
`ifdef IFID_ADEL_CHECK_EN
  logic        id_adel;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_id_buffer #(.DEPTH(2), .PTR_W(1)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (flush),
    .if_valid (if_valid),
    .if_ready (if_ready),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .id_valid (id_valid),
    .id_ready (id_ready),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
`ifdef IFID_ADEL_CHECK_EN
    .id_adel  (id_adel),
`endif
    .id_imm   (id_imm)
  );

  typedef struct {
    logic        flush;
    logic        if_valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        id_ready;
    logic        e_valid;
    logic        e_ready;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Outputs reflect state committed at the previous rising edge.
  task automatic chk_state(input string tag, input logic v, input logic r,
                           input logic [31:0] pc, input logic [31:0] inst);
    chk({tag, ".id_valid"}, 32'(id_valid), 32'(v));
    chk({tag, ".if_ready"}, 32'(if_ready), 32'(r));
    chk({tag, ".id_pc"},    id_pc,         pc);
    chk({tag, ".id_inst"},  id_inst,       inst);
    chk({tag, ".id_imm"},   32'(id_imm),   32'(inst[15:0]));
  endtask

  task automatic drive(input logic f, input logic v, input logic [31:0] pc,
                       input logic [31:0] inst, input logic r);
    flush    = f;
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    id_ready = r;
  endtask

  vec_t vecs [17];

  initial begin
    // flush, if_valid, pc, inst, id_ready | valid, ready, pc, inst
    vecs[0]  = '{0, 1, 32'hBFC0_0000, 32'h2402_FFFF, 1, 0, 1, 32'hBFC0_0000, 32'h0};
    vecs[1]  = '{0, 0, 32'h0,         32'h0,         1, 1, 1, 32'hBFC0_0000, 32'h2402_FFFF};
    vecs[2]  = '{0, 0, 32'h0,         32'h0,         1, 0, 1, 32'hBFC0_0000, 32'h0};
    vecs[3]  = '{0, 1, 32'h0000_0100, 32'h1111_0001, 0, 0, 1, 32'hBFC0_0000, 32'h0};
    vecs[4]  = '{0, 1, 32'h0000_0104, 32'h2222_0002, 0, 1, 1, 32'h0000_0100, 32'h1111_0001};
    vecs[5]  = '{0, 1, 32'h0000_0108, 32'h3333_0003, 0, 1, 0, 32'h0000_0100, 32'h1111_0001};
    vecs[6]  = '{0, 1, 32'h0000_0108, 32'h3333_0003, 1, 1, 0, 32'h0000_0100, 32'h1111_0001};
    vecs[7]  = '{0, 1, 32'h0000_0108, 32'h3333_0003, 1, 1, 1, 32'h0000_0104, 32'h2222_0002};
    vecs[8]  = '{0, 0, 32'h0,         32'h0,         1, 1, 1, 32'h0000_0108, 32'h3333_0003};
    vecs[9]  = '{0, 0, 32'h0,         32'h0,         1, 0, 1, 32'h0000_0108, 32'h0};
    vecs[10] = '{0, 1, 32'h0000_0200, 32'h4444_0004, 0, 0, 1, 32'h0000_0108, 32'h0};
    vecs[11] = '{0, 1, 32'h0000_0204, 32'h5555_0005, 0, 1, 1, 32'h0000_0200, 32'h4444_0004};
    vecs[12] = '{1, 1, 32'h0000_0208, 32'h6666_0006, 1, 1, 0, 32'h0000_0200, 32'h4444_0004};
    vecs[13] = '{0, 1, 32'h0000_020C, 32'h7777_0007, 0, 0, 1, 32'h0000_0108, 32'h0};
    vecs[14] = '{0, 0, 32'h0,         32'h0,         0, 1, 1, 32'h0000_020C, 32'h7777_0007};
    vecs[15] = '{1, 0, 32'h0,         32'h0,         1, 1, 1, 32'h0000_020C, 32'h7777_0007};
    vecs[16] = '{0, 0, 32'h0,         32'h0,         0, 0, 1, 32'h0000_0108, 32'h0};

    resetn = 1'b0;
    drive(0, 1, 32'hDEAD_BEE0, 32'hDEAD_BEEF, 0);
    repeat (3) @(negedge clk);
    chk_state("reset", 0, 1, 32'hBFC0_0000, 32'h0);
`ifdef IFID_ADEL_CHECK_EN
    chk("reset.id_adel", 32'(id_adel), 32'h0);
`endif
    drive(0, 0, 32'h0, 32'h0, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk_state("post_reset", 0, 1, 32'hBFC0_0000, 32'h0);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].flush, vecs[i].if_valid, vecs[i].pc, vecs[i].inst, vecs[i].id_ready);
      chk_state($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_ready,
                vecs[i].e_pc, vecs[i].e_inst);
      @(negedge clk);
    end

    // Simultaneous push and pop at count=1 across pointer wraps.
    drive(0, 1, 32'h0000_0300, 32'hA000_0000, 0);
    chk_state("pp_start", 0, 1, 32'h0000_0108, 32'h0);
    @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      drive(0, 1, 32'h0000_0300 + 32'(4 * k), 32'hA000_0000 | 32'(k), 1);
      chk_state($sformatf("pp%0d", k), 1, 1, 32'h0000_0300 + 32'(4 * (k - 1)),
                32'hA000_0000 | 32'(k - 1));
      @(negedge clk);
    end
    drive(0, 0, 32'h0, 32'h0, 1);
    chk_state("pp_last", 1, 1, 32'h0000_0320, 32'hA000_0008);
    @(negedge clk);
    drive(0, 0, 32'h0, 32'h0, 0);
    chk_state("pp_empty", 0, 1, 32'h0000_0320, 32'h0);

    // Reset asserted mid-cycle must drop the buffered entry at once.
    drive(0, 1, 32'h0000_0400, 32'h8888_0008, 0);
    @(negedge clk);
    drive(0, 0, 32'h0, 32'h0, 0);
    chk_state("pre_async", 1, 1, 32'h0000_0400, 32'h8888_0008);
    #2 resetn = 1'b0;
    #1 chk_state("async_reset", 0, 1, 32'hBFC0_0000, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

`ifdef IFID_ADEL_CHECK_EN
    drive(0, 1, 32'hBFC0_0002, 32'h1234_5678, 0);
    @(negedge clk);
    drive(0, 0, 32'h0, 32'h0, 1);
    chk_state("adel_mis", 1, 1, 32'hBFC0_0002, 32'h0);
    chk("adel_mis.id_adel", 32'(id_adel), 32'h1);
    @(negedge clk);
    drive(0, 1, 32'hBFC0_0004, 32'h1234_5678, 0);
    chk("adel_empty.id_adel", 32'(id_adel), 32'h0);
    @(negedge clk);
    drive(0, 0, 32'h0, 32'h0, 1);
    chk_state("adel_ok", 1, 1, 32'hBFC0_0004, 32'h1234_5678);
    chk("adel_ok.id_adel", 32'(id_adel), 32'h0);
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
